fwd_hazard_unit: RTL

- Parametrised forwarding and load-use hazard unit for the pipelined datapath.
- Tracks destination tags of in-flight instructions in an internal shift register of DEPTH stages (S1 = EX/MEM, S2 = MEM/WB, ...).
- Per cycle, produces a forwarding select for each of NUM_SRC operands of the EX-stage instruction.
- Detects load-use dependences of the ID-stage instruction, raises stall, and keeps a saturating stall counter.

---
 rtl/fwd_hazard_pkg.sv | 31 +++
 rtl/fwd_src_match.sv | 45 ++++
 rtl/fwd_hazard_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/fwd_hazard_pkg.sv
// fwd_hazard_pkg
//   Shared types and helpers for the forwarding / load-use hazard unit.
//   fwdEntry_t : one tracked in-flight instruction {v, rd, ld}.
//   FWD_*      : forwarding select encodings (0 = register file, k = stage Sk).
//   clog2      : elaboration-time ceil(log2(n)).
package fwd_hazard_pkg;

    // Destination field in an entry is sized for the widest register address
    // we expect; narrower REG_W values are zero-extended on entry.
    localparam int ENT_RD_W = 8;

    typedef struct packed {
        logic                v;
        logic [ENT_RD_W-1:0] rd;
        logic                ld;
    } fwdEntry_t;

    localparam int FWD_RF = 0;
    localparam int FWD_S1 = 1;
    localparam int FWD_S2 = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// fwd_src_match
//   Per-operand matcher against the tracked entries.
//   entries : [0] = candidate formed from the EX instruction, [1..DEPTH] = S1..S_DEPTH
//   exSrc   : EX-stage source register -> sel (0 = register file, k = Sk)
//   idSrc   : ID-stage source register -> ldPend (unresolvable load ahead of it)
module fwd_src_match
    import fwd_hazard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = 2
) (
    input  fwdEntry_t [DEPTH:0] entries,
    input  logic [REG_W-1:0]    exSrc,
    input  logic [REG_W-1:0]    idSrc,
    output logic [SEL_W-1:0]    sel,
    output logic                ldPend
);

    always_comb begin
        sel    = SEL_W'(FWD_RF);
        ldPend = 1'b0;

        // Walk oldest to youngest so the youngest hit overwrites. A youngest hit
        // that is a load not yet forwardable yields 0 rather than falling back to
        // an older (stale) producer. Entries with rd=0 are never valid, so a
        // zero source can never match.
        for (int k = DEPTH; k >= 1; k--) begin
            if (entries[k].v && entries[k].rd == ENT_RD_W'(exSrc)) begin
                sel = (entries[k].ld && k < LOAD_STAGE) ? SEL_W'(FWD_RF) : SEL_W'(k);
            end
        end

        // Position p (0 = EX) holds a load whose data arrives too late for the
        // ID instruction if it moved into EX next cycle.
        for (int p = 0; p + 1 < LOAD_STAGE; p++) begin
            if (idSrc != '0 && entries[p].v && entries[p].ld &&
                entries[p].rd == ENT_RD_W'(idSrc)) begin
                ldPend = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding-select and load-use stall generation for the pipelined datapath.
//   clk, rst            : clock, asynchronous active-high reset
//   pipe_en             : advance the tag shift register (0 = freeze, counter holds)
//   flush               : EX instruction squashed; S1 captures a bubble
//   ex_valid/ex_regwrite/ex_is_load/ex_rd/ex_src : EX-stage instruction
//   id_valid/id_src     : ID-stage instruction
//   fwd_sel             : per operand, 0 = register file, k = stage Sk
//   stall               : hold IF/ID and inject a bubble into EX
//   stall_cnt           : saturating count of stall cycles
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int CNT_W      = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   pipe_en,
    input  logic                                   flush,
    input  logic                                   ex_valid,
    input  logic                                   ex_regwrite,
    input  logic                                   ex_is_load,
    input  logic [REG_W-1:0]                       ex_rd,
    input  logic [NUM_SRC*REG_W-1:0]               ex_src,
    input  logic                                   id_valid,
    input  logic [NUM_SRC*REG_W-1:0]               id_src,
    output logic [NUM_SRC*clog2(DEPTH+1)-1:0]      fwd_sel,
    output logic                                   stall,
    output logic [CNT_W-1:0]                       stall_cnt
);

    localparam int SEL_W = clog2(DEPTH + 1);

    fwdEntry_t [DEPTH:1]             stages;
    fwdEntry_t                       exEnt;
    fwdEntry_t [DEPTH:0]             entries;
    logic [NUM_SRC-1:0][SEL_W-1:0]   selRaw;
    logic [NUM_SRC-1:0]              ldPend;

    // The EX instruction as it would be captured into S1; a flush kills it,
    // which also masks its contribution to the stall in the same cycle.
    always_comb begin
        exEnt.v  = ex_valid & ex_regwrite & ~flush & (ex_rd != '0);
        exEnt.rd = ENT_RD_W'(ex_rd);
        exEnt.ld = ex_is_load;
    end

    assign entries = {stages, exEnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= '0;
        end else if (pipe_en) begin
            stages[1] <= exEnt;
            for (int k = 2; k <= DEPTH; k++) stages[k] <= stages[k-1];
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : gMatch
        fwd_src_match #(
            .REG_W      (REG_W),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE),
            .SEL_W      (SEL_W)
        ) uMatch (
            .entries (entries),
            .exSrc   (ex_src[i*REG_W +: REG_W]),
            .idSrc   (id_src[i*REG_W +: REG_W]),
            .sel     (selRaw[i]),
            .ldPend  (ldPend[i])
        );
    end

    // Outputs are forced quiet while reset is held, not just after the edge.
    assign fwd_sel = rst ? '0 : selRaw;
    assign stall   = ~rst & id_valid & (|ldPend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (pipe_en && stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
